// File: rtl/boton_ar_multi.sv
// -----------------------------------------------------------------------------
// boton_ar_multi
//
// Multi-channel debouncer for active-low push buttons (idle level is 1).
// Each channel is independent and provides:
//   - a 2-FF synchroniser on the raw asynchronous input,
//   - a debounced level that only changes after COUNT_BOT consecutive
//     synchronised samples disagree with the current level,
//   - one-cycle press / release strobes aligned with the level change,
//   - a one-cycle long-press strobe once the level has stayed low for
//     LONG_COUNT cycles, plus a hold flag that stays high until release.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-low reset
//   boton_in       [N_BOT] raw button inputs, active-low, asynchronous
//   boton_out      [N_BOT] debounced level, active-low, idle 1
//   press_pulse    [N_BOT] 1-cycle strobe when boton_out goes 1->0
//   release_pulse  [N_BOT] 1-cycle strobe when boton_out goes 0->1
//   long_pulse     [N_BOT] 1-cycle strobe when a press reaches LONG_COUNT
//   hold           [N_BOT] high from long_pulse until release
// -----------------------------------------------------------------------------
module boton_ar_multi #(
    parameter int N_BOT      = 4,
    parameter int COUNT_BOT  = 50000,
    parameter int LONG_COUNT = 150000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BOT-1:0] boton_in,
    output logic [N_BOT-1:0] boton_out,
    output logic [N_BOT-1:0] press_pulse,
    output logic [N_BOT-1:0] release_pulse,
    output logic [N_BOT-1:0] long_pulse,
    output logic [N_BOT-1:0] hold
);

    localparam int CNT_W  = $clog2(COUNT_BOT + 1);
    localparam int HOLD_W = $clog2(LONG_COUNT + 1);

    // Last counter value before a new level is accepted / a long press fires.
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COUNT_BOT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_COUNT);

    // Saturating increment for the hold counter: it freezes at LONG_COUNT.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + HOLD_W'(1);
    endfunction

    for (genvar g = 0; g < N_BOT; g++) begin : g_ch
        logic              sync_p0;
        logic              sync_p1;
        logic [CNT_W-1:0]  db_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              hold_q;
        logic              accept;

        // The synchronised sample has disagreed with the level for COUNT_BOT
        // consecutive edges, counting this one: take the new level now.
        assign accept = (sync_p1 != level_q) && (db_cnt == CNT_LAST);

        always_ff @(posedge clk) begin
            if (!reset) begin
                sync_p0   <= 1'b1;
                sync_p1   <= 1'b1;
                db_cnt    <= '0;
                hold_cnt  <= '0;
                level_q   <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                hold_q    <= 1'b0;
            end else begin
                // stage p0 -> p1: two-flop synchroniser on the raw input
                sync_p0 <= boton_in[g];
                sync_p1 <= sync_p0;

                // stage p1 -> debounced level and strobes
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;

                if (sync_p1 != level_q) begin
                    db_cnt <= accept ? '0 : db_cnt + CNT_W'(1);
                end else begin
                    // Any agreeing sample restarts the count, so short
                    // glitches never reach the output.
                    db_cnt <= '0;
                end

                if (accept) begin
                    level_q  <= sync_p1;
                    hold_cnt <= '0;
                    if (!sync_p1) begin
                        press_q <= 1'b1;
                    end else begin
                        release_q <= 1'b1;
                        hold_q    <= 1'b0;
                    end
                end else if (!level_q && !hold_q) begin
                    // Long-press timing; release on the same edge wins above.
                    hold_cnt <= hold_inc(hold_cnt);
                    if (hold_cnt == HOLD_LAST) begin
                        long_q <= 1'b1;
                        hold_q <= 1'b1;
                    end
                end
            end
        end

        assign boton_out[g]     = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign long_pulse[g]    = long_q;
        assign hold[g]          = hold_q;
    end

endmodule

// File: tb/tb_boton_ar_multi.sv
// -----------------------------------------------------------------------------
// tb_boton_ar_multi
//
// Bench for boton_ar_multi with N_BOT=2, COUNT_BOT=5, LONG_COUNT=20.
// A behavioural model updated on every rising edge predicts all outputs from
// the input history; a compare process checks them on every falling edge.
// Directed scenarios add literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_boton_ar_multi;

    localparam int N  = 2;
    localparam int CB = 5;
    localparam int LC = 20;

    logic         clk;
    logic         reset;
    logic [N-1:0] boton_in;
    logic [N-1:0] boton_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] hold;

    int errors = 0;
    int checks = 0;

    boton_ar_multi #(
        .N_BOT      (N),
        .COUNT_BOT  (CB),
        .LONG_COUNT (LC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .boton_in      (boton_in),
        .boton_out     (boton_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .hold          (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The level flips once the last CB samples seen since the previous flip
    // (or reset) all differ from it. A long press fires exactly LC edges after
    // the press edge if the level is still low.
    logic [N-1:0] m_out, m_press, m_rel, m_long, m_hold;
    logic [N-1:0] m_d1, m_d2;
    bit [CB-1:0]  m_win [N];
    int           m_since [N];
    int           m_press_edge [N];
    bit           m_fired [N];
    int           edge_no = 0;
    bit           m_ok = 1'b0;

    always @(posedge clk) begin
        edge_no++;
        for (int c = 0; c < N; c++) begin
            logic smp;
            if (!reset) begin
                m_d1[c] = 1'b1;
                m_d2[c] = 1'b1;
                m_out[c] = 1'b1;
                m_press[c] = 1'b0;
                m_rel[c] = 1'b0;
                m_long[c] = 1'b0;
                m_hold[c] = 1'b0;
                m_win[c] = '0;
                m_since[c] = 0;
                m_fired[c] = 1'b0;
                m_press_edge[c] = 0;
            end else begin
                smp = m_d2[c];
                m_d2[c] = m_d1[c];
                m_d1[c] = boton_in[c];
                m_press[c] = 1'b0;
                m_rel[c] = 1'b0;
                m_long[c] = 1'b0;
                m_win[c] = {m_win[c][CB-2:0], smp};
                m_since[c]++;
                if (m_since[c] >= CB && m_win[c] == {CB{~m_out[c]}}) begin
                    m_out[c] = ~m_out[c];
                    m_since[c] = 0;
                    if (m_out[c] == 1'b0) begin
                        m_press[c] = 1'b1;
                        m_press_edge[c] = edge_no;
                        m_fired[c] = 1'b0;
                    end else begin
                        m_rel[c] = 1'b1;
                        m_hold[c] = 1'b0;
                    end
                end else if (m_out[c] == 1'b0 && !m_fired[c] && (edge_no - m_press_edge[c]) == LC) begin
                    m_long[c] = 1'b1;
                    m_fired[c] = 1'b1;
                    m_hold[c] = 1'b1;
                end
            end
        end
        if (!reset) m_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model boton_out", boton_out, m_out);
            chk("model press_pulse", press_pulse, m_press);
            chk("model release_pulse", release_pulse, m_rel);
            chk("model long_pulse", long_pulse, m_long);
            chk("model hold", hold, m_hold);
        end
    end

    // ---------------- stimulus ----------------
    int rem [N];

    initial begin
        reset    = 1'b0;
        boton_in = 2'b11;
        repeat (3) @(negedge clk);
        chk("reset boton_out", boton_out, 2'b11);
        chk("reset press", press_pulse, 2'b00);
        chk("reset release", release_pulse, 2'b00);
        chk("reset long", long_pulse, 2'b00);
        chk("reset hold", hold, 2'b00);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Press channel 0: level changes at edge 6, long press at edge 26.
        boton_in = 2'b10;
        repeat (6) @(negedge clk);
        chk("press edge5 boton_out", boton_out, 2'b11);
        @(negedge clk);
        chk("press edge6 boton_out", boton_out, 2'b10);
        chk("press edge6 press", press_pulse, 2'b01);
        @(negedge clk);
        chk("press edge7 press", press_pulse, 2'b00);
        repeat (19) @(negedge clk);
        chk("long edge26 long", long_pulse, 2'b01);
        chk("long edge26 hold", hold, 2'b01);
        @(negedge clk);
        chk("long edge27 long", long_pulse, 2'b00);
        chk("long edge27 hold", hold, 2'b01);
        repeat (13) @(negedge clk);

        // Release channel 0.
        boton_in = 2'b11;
        repeat (6) @(negedge clk);
        chk("release edge5 hold", hold, 2'b01);
        @(negedge clk);
        chk("release edge6 release", release_pulse, 2'b01);
        chk("release edge6 hold", hold, 2'b00);
        chk("release edge6 boton_out", boton_out, 2'b11);

        // Glitches of 1, 3 and 4 low cycles never change the level.
        for (int k = 0; k < 3; k++) begin
            int len;
            len = (k == 0) ? 1 : (k == 1) ? 3 : 4;
            repeat (10) @(negedge clk);
            boton_in = 2'b10;
            repeat (len) @(negedge clk);
            boton_in = 2'b11;
        end
        repeat (10) @(negedge clk);
        chk("glitch boton_out", boton_out, 2'b11);

        // Both channels pressed together, channel 1 released early.
        boton_in = 2'b00;
        repeat (7) @(negedge clk);
        chk("dual press", press_pulse, 2'b11);
        chk("dual boton_out", boton_out, 2'b00);
        repeat (4) @(negedge clk);
        boton_in = 2'b10;
        repeat (7) @(negedge clk);
        chk("ch1 release", release_pulse, 2'b10);
        chk("ch1 release long", long_pulse, 2'b00);
        repeat (9) @(negedge clk);
        chk("ch0 long only", long_pulse, 2'b01);
        chk("ch0 hold only", hold, 2'b01);

        // Reset while channel 0 is in hold, button kept pressed.
        reset = 1'b0;
        @(negedge clk);
        chk("midreset boton_out", boton_out, 2'b11);
        chk("midreset hold", hold, 2'b00);
        chk("midreset release", release_pulse, 2'b00);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("repress R+6 boton_out", boton_out, 2'b11);
        @(negedge clk);
        chk("repress R+7 press", press_pulse, 2'b01);
        chk("repress R+7 boton_out", boton_out, 2'b10);
        boton_in = 2'b11;
        repeat (10) @(negedge clk);

        // Randomized run: mostly long stable levels, some short bounces,
        // occasional reset.
        for (int c = 0; c < N; c++) rem[c] = 5;
        repeat (3000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) != 0);
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    boton_in[c] = ~boton_in[c];
                    if ($urandom_range(0, 3) == 0)
                        rem[c] = int'($urandom_range(0, 4));
                    else
                        rem[c] = int'($urandom_range(5, 40));
                end else begin
                    rem[c]--;
                end
            end
        end
        reset    = 1'b1;
        boton_in = 2'b11;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
